// File: rtl/anabellek_obek_yaniticisi_pkg.sv
// Shared definitions for the instruction-cache block-refill responder:
// state encodings, block geometry and the fill instruction.
package anabellek_obek_yaniticisi_pkg;

  localparam logic [2:0] BOSTA = 3'd0;
  localparam logic [2:0] OKU   = 3'd1;
  localparam logic [2:0] BEKLE = 3'd2;
  localparam logic [2:0] TAMAM = 3'd3;
  localparam logic [2:0] BIRAK = 3'd4;

  localparam int OBEK_KELIME_SAYISI  = 4;
  localparam int OBEK_OFSET_GENISLIK = 4;

  localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;

  function automatic logic [31:0] obekTabani(input logic [31:0] adres);
    return adres & ~((32'd1 << OBEK_OFSET_GENISLIK) - 32'd1);
  endfunction

  // The base is block aligned, so OR-ing in the word offset never carries.
  function automatic logic [31:0] kelimeAdresi(input logic [31:0] taban,
                                               input logic [1:0]  indeks);
    return taban | {28'd0, indeks, 2'b00};
  endfunction

endpackage

// File: rtl/anabellek_obek_yaniticisi_zaman_asimi_sayaci.sv
// Per-word wait counter. o_doldu rises at the start of the last permitted
// wait cycle, so the caller can still accept data in that same cycle.
module anabellek_zaman_asimi_sayaci
  import anabellek_obek_yaniticisi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_temizle,
  input  logic         i_etkin,
  input  logic [W-1:0] i_sinir,
  output logic         o_doldu
);

  logic [W-1:0] r_sayac;
  logic         r_doldu;
  logic [W:0]   w_sonraki;
  logic [W:0]   w_sonHedef;

  assign w_sonraki  = {1'b0, r_sayac} + (W+1)'(1);
  assign w_sonHedef = {1'b0, i_sinir} - (W+1)'(1);

  // A limit of one makes the first cycle of the wait already the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sayac <= '0;
      r_doldu <= 1'b0;
    end else if (i_temizle) begin
      r_sayac <= '0;
      r_doldu <= (i_sinir == W'(1));
    end else if (i_etkin && !r_doldu) begin
      r_sayac <= w_sonraki[W-1:0];
      if ((i_sinir != '0) && (w_sonraki == w_sonHedef)) begin
        r_doldu <= 1'b1;
      end
    end
  end

  assign o_doldu = r_doldu;

endmodule

// File: rtl/anabellek_obek_yaniticisi.sv
// Memory-side responder: fetches a 128-bit block as four single-outstanding
// word reads and returns it with a one-cycle valid pulse.
module anabellek_obek_yaniticisi
  import anabellek_obek_yaniticisi_pkg::*;
#(
  parameter int          ZAMAN_ASIMI  = 255,
  parameter logic [31:0] DOLGU_BUYRUK = NOP_BUYRUK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         anabellek_istek_g,
  input  logic [31:0]  anabellek_adres_g,
  output logic [127:0] anabellek_obek_c,
  output logic         anabellek_gecerli_obek_c,
  output logic         anabellek_hata_c,
  output logic         bellek_istek_c,
  output logic [31:0]  bellek_adres_c,
  input  logic         bellek_gecerli_g,
  input  logic [31:0]  bellek_veri_g
);

  localparam int SAYAC_W = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SAYAC_W-1:0] SAYAC_SINIRI = SAYAC_W'(ZAMAN_ASIMI);

  logic [2:0]                             r_durum;
  logic [31:0]                            r_taban;
  logic [1:0]                             r_indeks;
  logic                                   r_hataBayragi;
  logic [OBEK_KELIME_SAYISI-1:0][31:0]    r_tampon;

  logic [OBEK_KELIME_SAYISI-1:0][31:0]    w_tamponSonraki;
  logic                                   w_zamanAsimi;
  logic                                   w_doldu;
  logic                                   w_sayacEtkin;
  logic                                   w_sayacTemizle;
  logic [31:0]                            w_yeniTaban;

  assign w_yeniTaban    = obekTabani(anabellek_adres_g);
  assign w_sayacEtkin   = (r_durum == OKU) || (r_durum == BEKLE);
  assign w_sayacTemizle = !w_sayacEtkin || ((r_durum == BEKLE) && bellek_gecerli_g);

  anabellek_zaman_asimi_sayaci #(
    .W (SAYAC_W)
  ) u_sayac (
    .clk       (clk),
    .rst       (rst),
    .i_temizle (w_sayacTemizle),
    .i_etkin   (w_sayacEtkin),
    .i_sinir   (SAYAC_SINIRI),
    .o_doldu   (w_doldu)
  );

  // Data arriving in the final wait cycle takes priority over the timeout.
  always_comb begin
    w_tamponSonraki = r_tampon;
    w_zamanAsimi    = 1'b0;
    if (r_durum == BEKLE) begin
      if (bellek_gecerli_g) begin
        w_tamponSonraki[r_indeks] = bellek_veri_g;
      end else if ((ZAMAN_ASIMI != 0) && w_doldu) begin
        w_zamanAsimi = 1'b1;
        for (int i = 0; i < OBEK_KELIME_SAYISI; i++) begin
          if (i >= int'(r_indeks)) begin
            w_tamponSonraki[i[1:0]] = DOLGU_BUYRUK;
          end
        end
      end
    end
  end

  // Outputs are set on the edge entering the state they belong to, so the
  // read request is visible during OKU and the block pulse during TAMAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum                  <= BOSTA;
      r_taban                  <= '0;
      r_indeks                 <= '0;
      r_hataBayragi            <= 1'b0;
      r_tampon                 <= '0;
      anabellek_obek_c         <= '0;
      anabellek_gecerli_obek_c <= 1'b0;
      anabellek_hata_c         <= 1'b0;
      bellek_istek_c           <= 1'b0;
      bellek_adres_c           <= '0;
    end else begin
      bellek_istek_c           <= 1'b0;
      anabellek_gecerli_obek_c <= 1'b0;
      anabellek_hata_c         <= 1'b0;
      r_tampon                 <= w_tamponSonraki;
      case (r_durum)
        BOSTA: begin
          if (anabellek_istek_g) begin
            r_taban        <= w_yeniTaban;
            r_indeks       <= 2'd0;
            r_hataBayragi  <= 1'b0;
            bellek_istek_c <= 1'b1;
            bellek_adres_c <= kelimeAdresi(w_yeniTaban, 2'd0);
            r_durum        <= OKU;
          end
        end
        OKU: begin
          r_durum <= BEKLE;
        end
        BEKLE: begin
          if (bellek_gecerli_g && (r_indeks != 2'd3)) begin
            r_indeks       <= r_indeks + 2'd1;
            bellek_istek_c <= 1'b1;
            bellek_adres_c <= kelimeAdresi(r_taban, r_indeks + 2'd1);
            r_durum        <= OKU;
          end else if (bellek_gecerli_g || w_zamanAsimi) begin
            r_hataBayragi            <= w_zamanAsimi;
            anabellek_obek_c         <= w_tamponSonraki;
            anabellek_gecerli_obek_c <= 1'b1;
            anabellek_hata_c         <= r_hataBayragi | w_zamanAsimi;
            r_durum                  <= TAMAM;
          end
        end
        TAMAM: begin
          r_durum <= BIRAK;
        end
        BIRAK: begin
          if (!anabellek_istek_g) begin
            r_durum <= BOSTA;
          end
        end
        default: begin
          r_durum <= BOSTA;
        end
      endcase
    end
  end

endmodule

// File: doc/anabellek_obek_yaniticisi.md
Name: anabellek_obek_yaniticisi

Overview:
Main-memory-side responder for the instruction-cache block-refill protocol. Accepts a 128-bit block request (level request plus block address) from the instruction cache controller. Fetches the block as four sequential 32-bit reads over a single-outstanding word memory port. Returns the assembled block with a one-cycle valid pulse. Sits between the fetch-stage cache controller and the memory/bus word interface.

Parameters:
ZAMAN_ASIMI, 255, per-word wait limit in cycles; 0 disables the timeout.
DOLGU_BUYRUK, 32'h0000_0013, fill word (NOP) for block words not received before a timeout.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
anabellek_istek_g  input  1  block request level from the cache controller; held until after the valid pulse.
anabellek_adres_g  input  32  block address; bits [3:0] are ignored and forced to 0.
anabellek_obek_c  output  128  returned block; word k is at [32k+31:32k].
anabellek_gecerli_obek_c  output  1  one-cycle block-valid pulse.
anabellek_hata_c  output  1  one-cycle pulse, coincident with the valid pulse, when the block was completed by timeout.
bellek_istek_c  output  1  one-cycle word read request.
bellek_adres_c  output  32  word address; valid while bellek_istek_c=1.
bellek_gecerli_g  input  1  word data valid, latency ≥1 cycle after bellek_istek_c.
bellek_veri_g  input  32  word read data.

Behaviour:
- All outputs are registered. Reset value of every output is 0, and state is BOSTA.
- States: BOSTA, OKU, BEKLE, TAMAM, BIRAK.
- BOSTA: when anabellek_istek_g=1, latch base={adres_g[31:4],4'b0}, clear word index k (2 bits) and the timeout counter, then go to OKU.
- OKU: drive bellek_istek_c=1 for one cycle with bellek_adres_c=base+4k, then go to BEKLE.
- BEKLE: the counter increments each cycle.
  - On bellek_gecerli_g=1, store bellek_veri_g into buffer word k and clear the counter.
  - If k=3, go to TAMAM; otherwise k++ and go to OKU.
  - If ZAMAN_ASIMI≠0 and the counter reaches ZAMAN_ASIMI without valid, fill words k..3 with DOLGU_BUYRUK, set the error flag, and go to TAMAM.
- TAMAM: for one cycle, load anabellek_obek_c from the buffer and assert anabellek_gecerli_obek_c=1, plus anabellek_hata_c if the error flag is set. Then go to BIRAK.
- BIRAK: stay until anabellek_istek_g=0, then go to BOSTA. This prevents a second fetch from the controller's request, which is still high the cycle after the pulse.
- Latency: request seen in cycle 0, memory latency L. The valid pulse is in cycle 1+4(L+1); L=1 gives cycle 9.
- anabellek_obek_c changes only in TAMAM and holds its value otherwise.
- Ignored inputs:
  - bellek_gecerli_g outside BEKLE, including late data after reset or after a timeout.
  - anabellek_adres_g changes after acceptance.
  - anabellek_istek_g in any state other than BOSTA and BIRAK.
- Reset mid-transfer: immediate return to BOSTA; the buffer, index and flags clear; no valid pulse.
- bellek_gecerli_g in the same cycle the counter reaches the limit: the data wins and no timeout occurs.
- Address arithmetic: base+4k never carries out of bit 3.

Decomposition:
- Shared fetch package: state encodings for BOSTA/OKU/BEKLE/TAMAM/BIRAK, OBEK_KELIME_SAYISI=4, the NOP constant 32'h0000_0013, and the block-offset width 4.
- One sub-module: anabellek_zaman_asimi_sayaci.
  - Parameterised width.
  - Inputs: clear, enable, limit.
  - Output: registered doldu flag.

Test Plan:
1. Normal fetch: L=1 memory, request adres 0x0000_1234 → word reads at 0x1230, 0x1234, 0x1238, 0x123C with data A0..A3 → valid pulse in cycle 9, obek={A3,A2,A1,A0}, hata=0, pulse exactly one cycle.
2. Request release: after the valid pulse, istek stays high for 3 cycles → no bellek_istek_c. Next, istek low then high with 0x2000 → exactly one new fetch starting at 0x2000.
3. Timeout: ZAMAN_ASIMI=8, memory answers words 0 and 1 only → valid and hata pulse 8 cycles after the word-2 request, obek={13,13,W1,W0}. A late response to word 2 is then ignored.
4. Reset mid-op: rst for 1 cycle after word 1 is received → all outputs 0, state BOSTA. A late bellek_gecerli_g is ignored. A fresh request at 0x40 returns the correct block.
5. Noise: bellek_gecerli_g pulses in BOSTA, and adres_g changes to 0xFFF0 during a transfer → no effect; the block comes from the originally latched base.
6. Random latency 1..6 per word over 200 requests against a memory model → every block matches the model, exactly one pulse per request, hata never set.
